// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: widths, state encoding,
// and the index-width helper used by the arbiter and its priority picker.
package bus_arbiter_pkg;

    localparam int XLEN      = 32;
    localparam int BYTE_EN_W = XLEN / 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: the first set request found searching
// upward from (last + 1) mod N, wrapping around.
module rr_priority_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // The previous winner (off == N) is checked last, giving it lowest priority.
        for (int off = 1; off <= N; off++) begin
            k = (int'(last) + off) % N;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter muxing N bus masters onto one shared slave, with a
// per-master lock that keeps the grant across back-to-back transactions.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = bus_arbiter_pkg::XLEN
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_MASTERS-1:0]        i_m_bus_en,
    input  logic [N_MASTERS-1:0]        i_m_wr_en,
    input  logic [N_MASTERS*XLEN-1:0]   i_m_wr_data,
    input  logic [N_MASTERS*XLEN-1:0]   i_m_addr,
    input  logic [N_MASTERS*XLEN/8-1:0] i_m_byte_en,
    input  logic [N_MASTERS-1:0]        i_m_lock,
    output logic [N_MASTERS-1:0]        o_m_ack,
    output logic [XLEN-1:0]             o_m_rd_data,
    output logic [N_MASTERS-1:0]        o_grant,
    output logic                        o_bus_en,
    output logic                        o_wr_en,
    output logic [XLEN-1:0]             o_wr_data,
    output logic [XLEN-1:0]             o_addr,
    output logic [XLEN/8-1:0]           o_byte_en,
    input  logic                        i_ack,
    input  logic [XLEN-1:0]             i_rd_data
);

    localparam int IDX_W = idx_w(N_MASTERS);
    localparam int BE_W  = XLEN / 8;

    arb_state_t           state, state_nxt;
    logic [N_MASTERS-1:0] grant, grant_nxt;
    logic [IDX_W-1:0]     last, last_nxt;

    logic [N_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    rr_priority_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_m_bus_en),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    logic            sel_bus_en;
    logic            sel_wr_en;
    logic            sel_lock;
    logic [XLEN-1:0] sel_wr_data;
    logic [XLEN-1:0] sel_addr;
    logic [BE_W-1:0] sel_byte_en;
    logic            busy;

    // The grant register is zero outside BUSY, so the mux yields zeros there.
    always_comb begin
        sel_bus_en  = 1'b0;
        sel_wr_en   = 1'b0;
        sel_lock    = 1'b0;
        sel_wr_data = '0;
        sel_addr    = '0;
        sel_byte_en = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant[k]) begin
                sel_bus_en  = i_m_bus_en[k];
                sel_wr_en   = i_m_wr_en[k];
                sel_lock    = i_m_lock[k];
                sel_wr_data = i_m_wr_data[k*XLEN +: XLEN];
                sel_addr    = i_m_addr[k*XLEN +: XLEN];
                sel_byte_en = i_m_byte_en[k*BE_W +: BE_W];
            end
        end
    end

    assign busy        = (state == ARB_BUSY);
    assign o_bus_en    = busy & sel_bus_en;
    assign o_wr_en     = busy & sel_wr_en;
    assign o_wr_data   = busy ? sel_wr_data : '0;
    assign o_addr      = busy ? sel_addr : '0;
    assign o_byte_en   = busy ? sel_byte_en : '0;
    assign o_m_ack     = (busy && sel_bus_en && i_ack) ? grant : '0;
    assign o_m_rd_data = i_rd_data;
    assign o_grant     = grant;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        unique case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ARB_BUSY;
                    grant_nxt = pick_grant;
                    last_nxt  = pick_idx;
                end
            end
            ARB_BUSY: begin
                // Release on completion or abort unless the master holds its lock.
                if ((!sel_bus_en || i_ack) && !sel_lock) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
            grant <= '0;
            last  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters: single transfer, contention,
// lock, abort, stray ack and reset mid-transaction.
module tb_bus_arbiter;

    localparam int N = 2;
    localparam int X = 32;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   m_bus_en, m_wr_en, m_lock;
    logic [N*X-1:0] m_wr_data, m_addr;
    logic [N*X/8-1:0] m_byte_en;
    logic [N-1:0]   m_ack, grant;
    logic [X-1:0]   m_rd_data, wr_data, addr, rd_data;
    logic           bus_en, wr_en, ack;
    logic [X/8-1:0] byte_en;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.N_MASTERS(N), .XLEN(X)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_m_bus_en  (m_bus_en),
        .i_m_wr_en   (m_wr_en),
        .i_m_wr_data (m_wr_data),
        .i_m_addr    (m_addr),
        .i_m_byte_en (m_byte_en),
        .i_m_lock    (m_lock),
        .o_m_ack     (m_ack),
        .o_m_rd_data (m_rd_data),
        .o_grant     (grant),
        .o_bus_en    (bus_en),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data),
        .o_addr      (addr),
        .o_byte_en   (byte_en),
        .i_ack       (ack),
        .i_rd_data   (rd_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setm(input int k, input logic en, input logic wr, input logic [X-1:0] a,
                        input logic [X-1:0] d, input logic lk);
        m_bus_en[k]          = en;
        m_wr_en[k]           = wr;
        m_addr[k*X +: X]     = a;
        m_wr_data[k*X +: X]  = d;
        m_byte_en[k*4 +: 4]  = 4'hF;
        m_lock[k]            = lk;
    endtask

    initial begin
        logic [1:0] exp_g;
        i_rst = 1'b1;
        m_bus_en = '0; m_wr_en = '0; m_lock = '0;
        m_wr_data = '0; m_addr = '0; m_byte_en = '0;
        ack = 1'b0; rd_data = '0;
        tick(); tick();
        i_rst = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_bus_en", bus_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_m_ack", m_ack, 0);

        // Single master read
        setm(0, 1, 0, 32'h100, 0, 0);
        #1;
        chk("single_pre_bus_en", bus_en, 0);
        tick();
        chk("single_grant", grant, 2'b01);
        chk("single_bus_en", bus_en, 1);
        chk("single_addr", addr, 32'h100);
        chk("single_byte_en", byte_en, 4'hF);
        chk("single_wr_en", wr_en, 0);
        tick(); tick();
        chk("single_no_early_ack", m_ack, 0);
        ack = 1'b1; rd_data = 32'hDEADBEEF;
        #1;
        chk("single_ack", m_ack, 2'b01);
        chk("single_rd_data", m_rd_data, 32'hDEADBEEF);
        tick();
        ack = 1'b0; setm(0, 0, 0, 0, 0, 0);
        #1;
        chk("single_idle_grant", grant, 0);
        chk("single_idle_bus_en", bus_en, 0);
        chk("single_idle_ack", m_ack, 0);

        // Contention from reset: alternating M0, M1, M0, M1
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        setm(0, 1, 0, 32'h10, 0, 0);
        setm(1, 1, 0, 32'h20, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk("cont_grant", grant, exp_g);
            chk("cont_addr", addr, (i % 2 == 0) ? 32'h10 : 32'h20);
            ack = 1'b1;
            #1;
            chk("cont_ack", m_ack, exp_g);
            tick();
            ack = 1'b0;
            #1;
            chk("cont_idle_gap", grant, 0);
        end

        // Lock: M1 read locked, then write unlocked; M0 waits
        setm(0, 0, 0, 32'h300, 0, 0);
        setm(1, 1, 0, 32'h180, 0, 1);
        tick();
        chk("lock_grant1", grant, 2'b10);
        m_bus_en[0] = 1'b1;
        ack = 1'b1;
        #1;
        chk("lock_ack1", m_ack, 2'b10);
        tick();
        ack = 1'b0;
        setm(1, 1, 1, 32'h200, 32'h5, 0);
        #1;
        chk("lock_hold_grant", grant, 2'b10);
        chk("lock_fwd_bus_en", bus_en, 1);
        chk("lock_fwd_wr_en", wr_en, 1);
        chk("lock_fwd_addr", addr, 32'h200);
        chk("lock_fwd_data", wr_data, 32'h5);
        tick();
        chk("lock_still_m1", grant, 2'b10);
        ack = 1'b1;
        #1;
        chk("lock_ack2", m_ack, 2'b10);
        tick();
        ack = 1'b0;
        setm(1, 0, 0, 0, 0, 0);
        #1;
        chk("lock_release_idle", grant, 0);
        tick();
        chk("lock_m0_grant", grant, 2'b01);
        chk("lock_m0_addr", addr, 32'h300);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        setm(0, 0, 0, 0, 0, 0);

        // Abort then stray ack in IDLE
        setm(0, 1, 0, 32'h400, 0, 0);
        tick();
        chk("abort_grant", grant, 2'b01);
        m_bus_en[0] = 1'b0;
        #1;
        chk("abort_bus_en", bus_en, 0);
        tick();
        chk("abort_idle", grant, 0);
        ack = 1'b1;
        #1;
        chk("stray_ack", m_ack, 0);
        chk("stray_bus_en", bus_en, 0);
        ack = 1'b0;

        // Reset mid-transaction; pointer must return to N-1
        setm(0, 1, 0, 32'h500, 0, 0);
        tick();
        chk("rstmid_grant", grant, 2'b01);
        setm(1, 1, 0, 32'h600, 0, 0);
        i_rst = 1'b1;
        tick();
        chk("rstmid_grant_clr", grant, 0);
        chk("rstmid_bus_en", bus_en, 0);
        i_rst = 1'b0;
        ack = 1'b1;
        #1;
        chk("rstmid_stray_ack", m_ack, 0);
        ack = 1'b0;
        tick();
        chk("rstmid_first_m0", grant, 2'b01);
        chk("rstmid_addr", addr, 32'h500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
